intersection_ctrl: RTL

Two-way intersection controller that drives the traffic lights of two `car_lane` instances, lane A and lane B, and releases their queued cars. It reads each lane's `car_counter` and runs a green/yellow/all-red phase FSM with minimum and maximum green times. While a lane is green and its queue is non-empty, it emits one-cycle cross pulses on that lane's `signal_car_to_cross_if_green_in`. It sits at top level, between the two lane instances.

---
 rtl/car_types_pkg.sv | 35 +++
 rtl/phase_timer.sv | 23 ++
 rtl/intersection_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/car_types_pkg.sv
// Shared lane/intersection types: light colours, queue depth and controller phases.
package car_types_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } strafic_light_t;

    typedef logic [3:0] car_counter_t;

    typedef enum logic [2:0] {
        A_GREEN,
        A_YELLOW,
        RED_AB,
        B_GREEN,
        B_YELLOW,
        RED_BA
    } phase_t;

    // Light shown to lane A (lane_b=0) or lane B (lane_b=1) in a given phase.
    function automatic strafic_light_t light_for(input phase_t p, input logic lane_b);
        strafic_light_t l;
        l = RED;
        case (p)
            A_GREEN:  if (!lane_b) l = GREEN;
            A_YELLOW: if (!lane_b) l = YELLOW;
            B_GREEN:  if (lane_b)  l = GREEN;
            B_YELLOW: if (lane_b)  l = YELLOW;
            default:  l = RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase-age counter; i_clear restarts it at 0 on the edge a new phase begins.
module phase_timer #(
    parameter int MAX = 32,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    output logic [W-1:0] o_t
);

    logic [W-1:0] r_t;

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_t <= '0;
        else if (r_t != W'(MAX))
            r_t <= r_t + 1'b1;
    end

    assign o_t = r_t;

endmodule

// File: rtl/intersection_ctrl.sv
// Two-lane traffic phase controller: green/yellow/all-red sequencing with
// min/max green and spaced cross pulses toward the lane that holds green.
module intersection_ctrl
    import car_types_pkg::*;
#(
    parameter int GREEN_MIN      = 8,
    parameter int GREEN_MAX      = 32,
    parameter int YELLOW_CYCLES  = 4,
    parameter int ALL_RED_CYCLES = 2,
    parameter int CROSS_INTERVAL = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  car_counter_t   car_counter_a,
    input  car_counter_t   car_counter_b,
    output strafic_light_t light_a,
    output strafic_light_t light_b,
    output logic           cross_a,
    output logic           cross_b
);

    localparam int TW = $clog2(GREEN_MAX + 1);
    localparam int CW = $clog2(CROSS_INTERVAL);

    phase_t         r_state, w_next_state;
    logic [CW-1:0]  r_c, w_next_c;
    logic [TW-1:0]  w_t;
    logic           w_c_last, w_exit_a, w_exit_b, w_change, w_next_green;
    strafic_light_t r_light_a, r_light_b;
    logic           r_cross_a, r_cross_b;

    phase_timer #(.MAX(GREEN_MAX)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_change),
        .o_t     (w_t)
    );

    // Exits only at the end of a cross window so an issued pulse lands while still GREEN.
    assign w_c_last = (r_c == CW'(CROSS_INTERVAL - 1));
    assign w_exit_a = (car_counter_b != '0) &&
                      (((w_t >= TW'(GREEN_MIN - 1)) && (car_counter_a == '0)) ||
                       (w_t >= TW'(GREEN_MAX - 1)));
    assign w_exit_b = (car_counter_a != '0) &&
                      (((w_t >= TW'(GREEN_MIN - 1)) && (car_counter_b == '0)) ||
                       (w_t >= TW'(GREEN_MAX - 1)));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            A_GREEN:  if (w_c_last && w_exit_a)                w_next_state = A_YELLOW;
            A_YELLOW: if (w_t == TW'(YELLOW_CYCLES - 1))       w_next_state = RED_AB;
            RED_AB:   if (w_t == TW'(ALL_RED_CYCLES - 1))      w_next_state = B_GREEN;
            B_GREEN:  if (w_c_last && w_exit_b)                w_next_state = B_YELLOW;
            B_YELLOW: if (w_t == TW'(YELLOW_CYCLES - 1))       w_next_state = RED_BA;
            RED_BA:   if (w_t == TW'(ALL_RED_CYCLES - 1))      w_next_state = A_GREEN;
            default:                                           w_next_state = RED_BA;
        endcase
    end

    assign w_change     = (w_next_state != r_state);
    assign w_next_green = (w_next_state == A_GREEN) || (w_next_state == B_GREEN);
    assign w_next_c     = (!w_next_green || w_change || w_c_last) ? '0 : r_c + 1'b1;

    // Outputs decode next-state so lights and pulses move on the same edge as the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RED_BA;
            r_c       <= '0;
            r_light_a <= RED;
            r_light_b <= RED;
            r_cross_a <= 1'b0;
            r_cross_b <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_c       <= w_next_c;
            r_light_a <= light_for(w_next_state, 1'b0);
            r_light_b <= light_for(w_next_state, 1'b1);
            r_cross_a <= (w_next_state == A_GREEN) && (w_next_c == '0) && (car_counter_a != '0);
            r_cross_b <= (w_next_state == B_GREEN) && (w_next_c == '0) && (car_counter_b != '0);
        end
    end

    assign light_a = r_light_a;
    assign light_b = r_light_b;
    assign cross_a = r_cross_a;
    assign cross_b = r_cross_b;

endmodule
